alu_clk_rst_seq: RTL
====================

# alu_clk_rst_seq

Reset sequencer and lock supervisor for the ALU clock domain, on the opposite side of the clock wizard's reset/locked interface. It drives the wizard's active-high `reset`, synchronizes the wizard's `locked` status, and releases the ALU and core resets in a fixed order only after lock has been stable for a programmed time. It reasserts the downstream resets immediately on loss of lock, counts lock-loss events, and flags a relock timeout.

## Interface
- `PLL_RST_CYCLES`, default 8: number of cycles `pll_reset` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, default 64: number of consecutive synchronized-locked cycles required before releasing resets (≥1).
- `STAGE_GAP`, default 16: number of cycles between reset-release stages (≥1).
- `RELOCK_TIMEOUT`, default 4096: maximum number of cycles in WAIT_LOCK before the PLL is reset again; must be > `LOCK_STABLE_CYCLES`.
- `clk  in  1`: free-running reference clock, the wizard's `clk_in1` source.
- `rst_n  in  1`: asynchronous, active-low reset.
- `locked  in  1`: wizard lock status; asynchronous to `clk`.
- `clear_err  in  1`: synchronous clear for `timeout_err`.
- `pll_reset  out  1`: active-high reset to the wizard.
- `alu_rst_n  out  1`: active-low reset for the ALU domain; released first.
- `core_rst_n  out  1`: active-low reset for the core; released second.
- `ready  out  1`: high while in RUN.
- `lock_loss_cnt  out  8`: saturating count of lock losses after release began.
- `timeout_err  out  1`: sticky relock-timeout flag.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`. `locked_s` is the only form of `locked` used.
- FSM states: PLL_RST, WAIT_LOCK, REL_ALU, REL_CORE, RUN. One shared cycle counter `cnt` is cleared on every state change.
- Timeout counter `tcnt` counts every cycle spent in WAIT_LOCK and is cleared on entry to WAIT_LOCK.
- PLL_RST:
  - `pll_reset`=1.
  - After `PLL_RST_CYCLES` edges, go to WAIT_LOCK.
  - `locked_s` is ignored in this state.
- WAIT_LOCK:
  - `pll_reset`=0.
  - `cnt` increments on each edge where `locked_s`=1 and clears on each edge where `locked_s`=0.
  - On the edge where `locked_s`=1 and `cnt`==`LOCK_STABLE_CYCLES`-1, go to REL_ALU.
  - Otherwise, on the edge where `tcnt`==`RELOCK_TIMEOUT`-1: set `timeout_err` and go to PLL_RST.
  - If lock completion and timeout occur on the same edge, lock completion wins.
- REL_ALU:
  - `alu_rst_n`=1.
  - After `STAGE_GAP` edges, go to REL_CORE.
- REL_CORE:
  - `alu_rst_n`=1, `core_rst_n`=1.
  - After `STAGE_GAP` edges, go to RUN.
- RUN: `alu_rst_n`=1, `core_rst_n`=1, `ready`=1.
- Lock loss in REL_ALU, REL_CORE or RUN (`locked_s`=0 at an edge):
  - On that same edge, `alu_rst_n`, `core_rst_n` and `ready` go to 0.
  - `lock_loss_cnt` increments, saturating at 255.
  - The FSM goes to WAIT_LOCK; the PLL is not reset.
  - A `locked_s` drop in WAIT_LOCK only clears `cnt` and is not counted.
- `clear_err`=1 clears `timeout_err` on the next edge. If a timeout sets `timeout_err` on the same edge, the set wins.
- All outputs are registered, with no combinational path from any input to any output.

## Timing
- Values during and directly after `rst_n`=0:
  - `pll_reset`=1, `alu_rst_n`=0, `core_rst_n`=0, `ready`=0.
  - `lock_loss_cnt`=0, `timeout_err`=0.
  - Synchronizer flops = 0, state = PLL_RST, `cnt`=0.
- Reset assertion mid-operation forces these values asynchronously from any state.
- After `rst_n` deasserts, `pll_reset` stays 1 for exactly `PLL_RST_CYCLES` rising edges.
- Release latency, with `locked` first sampled high at edge k and held high:
  - `locked_s`=1 after edge k+1.
  - `alu_rst_n` rises after edge k+1+`LOCK_STABLE_CYCLES`.
  - `core_rst_n` rises `STAGE_GAP` edges after `alu_rst_n`.
  - `ready` rises `STAGE_GAP` edges after `core_rst_n`.
- Lock-loss latency: `locked` sampled low at edge j means all downstream resets are asserted after edge j+2.
- A `locked` glitch shorter than one `clk` period may be missed; this is acceptable.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `STAGE_GAP`=4, `RELOCK_TIMEOUT`=100.
- Power-up: `rst_n` low 3 cycles, then high; `locked`=1 from edge 10 onward.
  - `pll_reset` is high for exactly 4 edges after release.
  - `alu_rst_n` rises after edge 19, `core_rst_n` after edge 23, `ready` after edge 27.
- Unstable lock: `locked` toggles 1 for 5 cycles, 0 for 1 cycle, repeatedly, then stays 1.
  - `alu_rst_n` rises only 9 edges after the final rise.
  - `lock_loss_cnt` stays 0.
- Loss in RUN: drop `locked` for 3 cycles, then restore.
  - Resets assert 2 edges after the drop, with `lock_loss_cnt`=1 and no `pll_reset` pulse.
  - The full release sequence then repeats.
- Timeout: hold `locked`=0.
  - `timeout_err`=1 and a new 4-cycle `pll_reset` pulse every 104 cycles.
  - `clear_err` on the same edge as a timeout leaves `timeout_err`=1.
- Saturation: force 260 lock losses in RUN; `lock_loss_cnt` ends at 255.
- Async reset mid-REL_CORE: pull `rst_n` low between clock edges.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - `lock_loss_cnt` returns to 0.

Source files
------------

// File: rtl/alu_clk_rst_seq.sv
// Reset sequencer and lock supervisor for the ALU clock domain: drives the clock wizard reset,
// waits for a stable lock, then releases the ALU and core resets in order.
module alu_clk_rst_seq #(
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int STAGE_GAP          = 16,
    parameter int RELOCK_TIMEOUT     = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       clear_err,
    output logic       pll_reset,
    output logic       alu_rst_n,
    output logic       core_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic       timeout_err
);
    localparam int CNT_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (CNT_A > STAGE_GAP) ? CNT_A : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TCNT_W  = $clog2(RELOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(RELOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_REL_ALU,
        S_REL_CORE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               sync1_q, locked_s_q;
    logic               pll_reset_q, pll_reset_d;
    logic               alu_rst_n_q, alu_rst_n_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               ready_q, ready_d;
    logic [7:0]         loss_cnt_q, loss_cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               lock_done;
    logic               timeout_set;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        tcnt_d      = tcnt_q;
        loss_cnt_d  = loss_cnt_q;
        timeout_set = 1'b0;
        lock_done   = 1'b0;

        unique case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PLL_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            end
            S_WAIT_LOCK: begin
                tcnt_d    = tcnt_q + 1'b1;
                lock_done = locked_s_q && (cnt_q == LOCK_LAST);
                if (!locked_s_q) begin
                    cnt_d = '0;
                end
                // Lock completion takes priority over a coincident timeout.
                if (lock_done) begin
                    state_d = S_REL_ALU;
                    cnt_d   = '0;
                end else if (tcnt_q == TO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = S_PLL_RST;
                    cnt_d       = '0;
                end
            end
            S_REL_ALU, S_REL_CORE, S_RUN: begin
                if (state_q == S_RUN) begin
                    cnt_d = cnt_q;
                end
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end else if (state_q != S_RUN && cnt_q == GAP_LAST) begin
                    state_d = (state_q == S_REL_ALU) ? S_REL_CORE : S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        pll_reset_d   = (state_d == S_PLL_RST);
        alu_rst_n_d   = (state_d == S_REL_ALU) || (state_d == S_REL_CORE) || (state_d == S_RUN);
        core_rst_n_d  = (state_d == S_REL_CORE) || (state_d == S_RUN);
        ready_d       = (state_d == S_RUN);
        timeout_err_d = timeout_set || (timeout_err_q && !clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            state_q       <= S_PLL_RST;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            pll_reset_q   <= 1'b1;
            alu_rst_n_q   <= 1'b0;
            core_rst_n_q  <= 1'b0;
            ready_q       <= 1'b0;
            loss_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            sync1_q       <= locked;
            locked_s_q    <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            pll_reset_q   <= pll_reset_d;
            alu_rst_n_q   <= alu_rst_n_d;
            core_rst_n_q  <= core_rst_n_d;
            ready_q       <= ready_d;
            loss_cnt_q    <= loss_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign alu_rst_n     = alu_rst_n_q;
    assign core_rst_n    = core_rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign timeout_err   = timeout_err_q;
endmodule
